// File: rtl/operand_fetch_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | operand_fetch_stage_pkg : shared register/selector types           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package operand_fetch_stage_pkg;

  typedef logic [2:0] reg_idx_t;
  typedef logic [3:0] sel_b_t;

  localparam int     NUM_REGS  = 8;
  localparam sel_b_t SEL_B_IMM = 4'd8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Side B reads the register file only for selector values 0..7.
  function automatic logic sel_b_is_reg(input sel_b_t s);
    return s < sel_b_t'(NUM_REGS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/operand_fetch_stage_register_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | register_bank : 8-entry register file, 1 write / 2 async reads     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module register_bank
  import operand_fetch_stage_pkg::*;
#(
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [2:0]           wr_idx,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic [2:0]           rd_a_idx,
  output logic [WORD_SIZE-1:0] rd_a_data,
  input  logic [2:0]           rd_b_idx,
  output logic [WORD_SIZE-1:0] rd_b_data
);

  logic [WORD_SIZE-1:0] mem_q [NUM_REGS];
  logic [WORD_SIZE-1:0] mem_d [NUM_REGS];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_a_data = mem_q[rd_a_idx];
  assign rd_b_data = mem_q[rd_b_idx];

endmodule
`default_nettype wire

// File: rtl/operand_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | operand_fetch_stage : register file, RAW/WAW scoreboard, operand   |
// | bypass and single-entry output slot feeding the ALU. Rev 1.0       |
// +--------------------------------------------------------------------+
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           sel_a,
  input  logic [3:0]           sel_b,
  input  logic [WORD_SIZE-1:0] imm8,
  input  logic [2:0]           dest,
  input  logic                 dest_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] op_a,
  output logic [WORD_SIZE-1:0] op_b,
  output logic [2:0]           out_dest,
  output logic                 out_dest_en,
  input  logic                 wb_en,
  input  logic [2:0]           wb_sel,
  input  logic [WORD_SIZE-1:0] wb_data
);

  slot_state_t          state_q, state_d;
  logic [NUM_REGS-1:0]  pending_q, pending_d;
  logic [NUM_REGS-1:0]  clear_mask, pending_live;
  logic [WORD_SIZE-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2:0]           out_dest_q, out_dest_d;
  logic                 out_dest_en_q, out_dest_en_d;

  logic [WORD_SIZE-1:0] rd_a, rd_b;
  logic                 b_used, hazard, accept;

  register_bank #(.WORD_SIZE(WORD_SIZE)) u_bank (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wb_en),
    .wr_idx    (wb_sel),
    .wr_data   (wb_data),
    .rd_a_idx  (sel_a),
    .rd_a_data (rd_a),
    .rd_b_idx  (sel_b[2:0]),
    .rd_b_data (rd_b)
  );

  // A write-back this cycle retires its register's pending bit early, so
  // hazard detection looks at the scoreboard with that bit already cleared.
  always_comb begin
    clear_mask = '0;
    if (wb_en) begin
      clear_mask[wb_sel] = 1'b1;
    end
    pending_live = pending_q & ~clear_mask;
    b_used       = sel_b_is_reg(sel_b);
    hazard       = pending_live[sel_a]
                 | (b_used  & pending_live[sel_b[2:0]])
                 | (dest_en & pending_live[dest]);
    in_ready     = !hazard && ((state_q == SLOT_EMPTY) || out_ready);
    accept       = in_valid && in_ready;
  end

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_live;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    out_dest_d    = out_dest_q;
    out_dest_en_d = out_dest_en_q;

    if (accept) begin
      state_d       = SLOT_FULL;
      out_dest_d    = dest;
      out_dest_en_d = dest_en;
      op_a_d        = (wb_en && (wb_sel == sel_a)) ? wb_data : rd_a;
      if (b_used) begin
        op_b_d = (wb_en && (wb_sel == sel_b[2:0])) ? wb_data : rd_b;
      end else if (sel_b_t'(sel_b) == SEL_B_IMM) begin
        op_b_d = imm8;
      end else begin
        op_b_d = '0;
      end
      // Set is applied after clear so a same-cycle set on the same bit wins.
      if (dest_en) begin
        pending_d[dest] = 1'b1;
      end
    end else if ((state_q == SLOT_FULL) && out_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SLOT_EMPTY;
      pending_q     <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      out_dest_q    <= '0;
      out_dest_en_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      out_dest_q    <= out_dest_d;
      out_dest_en_q <= out_dest_en_d;
    end
  end

  assign out_valid   = (state_q == SLOT_FULL);
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign out_dest    = out_dest_q;
  assign out_dest_en = out_dest_en_q;

endmodule
`default_nettype wire

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Pipeline stage directly upstream of the ALU side-A and side-B operand muxes: holds the 8-entry general register file and captures both ALU operands into an output register. Side B can select the instruction's 8-bit immediate instead of a register. The ALU output demux feeds write-back into this stage. A per-register scoreboard stalls the decoder on read-after-write and write-after-write hazards.

## Interface
Parameters:
- WORD_SIZE, 8, datapath width of registers, immediate and operands

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  decoder presents an operation
- in_ready  out  1  stage accepts the operation this cycle
- sel_a  in  3  side-A source register 0..7
- sel_b  in  4  side-B source: 0..7 register, 8 immediate, 9..15 no-connect (zero)
- imm8  in  WORD_SIZE  immediate operand
- dest  in  3  destination register of the operation
- dest_en  in  1  operation writes dest
- out_valid  out  1  operands held for the ALU
- out_ready  in  1  ALU consumes the held operands
- op_a, op_b  out  WORD_SIZE  captured operands
- out_dest  out  3  captured dest
- out_dest_en  out  1  captured dest_en
- wb_en  in  1  write-back strobe from the ALU output path
- wb_sel  in  3  write-back register
- wb_data  in  WORD_SIZE  write-back value

## Operation
- Register file: 8 x WORD_SIZE. All entries reset to 0. When wb_en is high, reg[wb_sel] <= wb_data. Write-back is always accepted, pending or not.
- Output slot has two states, EMPTY and FULL.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on out_ready without accept.
  - FULL stays FULL on a simultaneous out_ready and accept.
- A source is "used" as follows: sel_a is always used. sel_b is used only when sel_b <= 7.
- hazard = any used source is pending and not cleared this cycle, OR (dest_en and pending[dest] and not cleared this cycle).
  - "Cleared this cycle" means wb_en && wb_sel == that register.
- in_ready = !hazard && (state==EMPTY || out_ready). accept = in_valid && in_ready.
- Operand capture on accept:
  - op_a = (wb_en && wb_sel==sel_a) ? wb_data : reg[sel_a].
  - op_b: same bypass for sel_b 0..7; imm8 for sel_b 8; 0 for sel_b 9..15.
- Scoreboard pending[7:0]:
  - Bits reset to 0.
  - Set on accept with dest_en for bit dest.
  - Cleared on wb_en for bit wb_sel.
  - If set and clear hit the same bit in one cycle, set wins.
- Outputs op_a, op_b, out_dest and out_dest_en change only on accept and hold otherwise.

## Timing
- Reset values: in_ready=1, out_valid=0, op_a=0, op_b=0, out_dest=0, out_dest_en=0, all pending=0.
- Asserting reset mid-operation discards the held entry and the scoreboard immediately (asynchronous).
- Latency: accept at edge N gives out_valid high after edge N; operands are visible in cycle N+1.
- Throughput: one operation per cycle while out_ready=1 and there are no hazards.
- in_ready is combinational from out_ready, wb_en, wb_sel, the selectors and pending. It has no path from in_valid.
- A write-back in the same cycle as an accept that reads the same register is forwarded: the new value is captured, with no stall.
- A write-back in the same cycle as a read of the same register through the held output does not alter op_a or op_b.
- The decoder must hold all request inputs stable while in_valid=1 and in_ready=0.

## Structure
- Shared package (used by the mux and decoder blocks too):
  - reg_idx_t (3-bit).
  - sel_b_t (4-bit).
  - Constants SEL_B_IMM=8 and NUM_REGS=8.
- One sub-module: register_bank, an 8 x WORD_SIZE array with one write port and two asynchronous read ports, async-reset to 0.
- Scoreboard, hazard logic, bypass and output slot stay in operand_fetch_stage.

## Test plan
- Reset, then write-back reg3=0x5A; accept sel_a=3, sel_b=8, imm8=0x11 -> next cycle out_valid=1, op_a=0x5A, op_b=0x11.
- Accept sel_b=12 -> op_b=0x00. Accept sel_a=0 straight after reset -> op_a=0x00.
- Accept dest=2 with dest_en=1, then request sel_a=2 -> in_ready=0 until a cycle with wb_en=1, wb_sel=2, wb_data=0x77. That cycle accepts with op_a=0x77 (bypass); pending[2] is cleared next cycle.
- Hold out_ready=0 with FULL -> in_ready=0 and outputs stable for 5 cycles. Raise out_ready together with in_valid -> back-to-back transfer, out_valid stays 1.
- Request dest=4 with dest_en=1 while pending[4]=1 -> stall (WAW). Same-cycle wb to reg4 plus a new accept with dest=4 -> pending[4] remains 1.
- Assert reset while FULL with pending[1]=1 -> out_valid=0, pending all 0, register file 0, in_ready=1 in the same cycle.
